// File: rtl/dram_user_adapter_if.sv
// Signal bundle between the core-side request/response channel, the adapter and the
// DRAM controller FIFO user interface; slave = adapter view, master = core/controller view.
interface dram_user_adapter_if #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 128,
    parameter int DRAM_ADDR_W = 28,
    parameter int DRAM_DATA_W = 144,
    parameter int TAG_W       = 4
);
    // Core channel: a beat transfers on any cycle where req_val & req_rdy are both high;
    // responses are pushed with resp_val and cannot be back-pressured.
    logic                   req_val;
    logic                   req_rdy;
    logic                   req_rw;
    logic [ADDR_W-1:0]      req_addr;
    logic [TAG_W-1:0]       req_tag;
    logic [DATA_W-1:0]      req_data;
    logic                   resp_val;
    logic [DATA_W-1:0]      resp_data;
    logic [TAG_W-1:0]       resp_tag;
    logic                   resp_last;
    logic                   err_unexp;
    logic [DRAM_ADDR_W-1:0] dram_addr;
    logic                   dram_read;
    logic                   dram_write_af;
    logic                   dram_af_full;
    logic [DRAM_DATA_W-1:0] dram_wdata;
    logic                   dram_write_wb;
    logic                   dram_wb_full;
    logic [DRAM_DATA_W-1:0] dram_rdata;
    logic                   dram_read_rb;
    logic                   dram_rb_empty;
    logic                   dram_rb_full;
    logic [31:0]            stat_rd;
    logic [31:0]            stat_wr;

    modport slave (
        input  req_val, req_rw, req_addr, req_tag, req_data,
        input  dram_af_full, dram_wb_full, dram_rdata, dram_rb_empty, dram_rb_full,
        output req_rdy, resp_val, resp_data, resp_tag, resp_last, err_unexp,
        output dram_addr, dram_read, dram_write_af, dram_wdata, dram_write_wb, dram_read_rb,
        output stat_rd, stat_wr
    );

    modport master (
        output req_val, req_rw, req_addr, req_tag, req_data,
        output dram_af_full, dram_wb_full, dram_rdata, dram_rb_empty, dram_rb_full,
        input  req_rdy, resp_val, resp_data, resp_tag, resp_last, err_unexp,
        input  dram_addr, dram_read, dram_write_af, dram_wdata, dram_write_wb, dram_read_rb,
        input  stat_rd, stat_wr
    );
endinterface

// File: rtl/dram_user_adapter.sv
// Bridge from the core memory channel to the DRAM controller address/write/read FIFOs,
// with read credits and tag return. Optional command counters: define DRAMIF_STATS_EN.
module dram_user_adapter #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 128,
    parameter int DRAM_ADDR_W = 28,
    parameter int DRAM_DATA_W = 144,
    parameter int BEATS       = 2,
    parameter int TAG_W       = 4,
    parameter int MAX_OUT     = 8,
    parameter int INIT_CYCLES = 8192
) (
    input logic gclk,
    input logic rst,
    dram_user_adapter_if.slave bus
);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW     = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW     = PW + 1;
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0]     MAX_CNT   = CW'(MAX_OUT);
    localparam logic [INIT_W-1:0] INIT_DONE = INIT_W'(INIT_CYCLES);

    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic              af_full_q, wb_full_q, rb_full_q;
    logic [BW-1:0]     wcnt_q, wcnt_d;
    logic [BW-1:0]     rcnt_q, rcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     out_cnt_q, out_cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              err_q, err_d;
    logic [TAG_W-1:0]  tag_mem_q [MAX_OUT];

    logic ready_init, base_rdy, rd_credit, req_rdy;
    logic wr_acc, rd_acc, wr_last, pop, pop_last;

    assign ready_init = (init_cnt_q == INIT_DONE);
    assign base_rdy   = ready_init & ~af_full_q & ~wb_full_q & ~rb_full_q;
    // Reads wait for the end of any write burst so AF entries never interleave with one.
    assign rd_credit  = (wcnt_q == '0) && (out_cnt_q < MAX_CNT);
    assign req_rdy    = ~rst & base_rdy & (bus.req_rw | rd_credit);
    assign wr_acc     = bus.req_val & req_rdy & bus.req_rw;
    assign rd_acc     = bus.req_val & req_rdy & ~bus.req_rw;
    assign wr_last    = wr_acc & (wcnt_q == LAST_BEAT);
    assign pop        = ~rst & ~bus.dram_rb_empty & (out_cnt_q != '0);
    assign pop_last   = pop & (rcnt_q == LAST_BEAT);

    always_comb begin
        bus.req_rdy       = req_rdy;
        bus.dram_write_wb = wr_acc;
        bus.dram_wdata    = DRAM_DATA_W'(bus.req_data);
        bus.dram_write_af = wr_last | rd_acc;
        bus.dram_read     = rd_acc;
        bus.dram_addr     = '0;
        if (rd_acc) begin
            bus.dram_addr = DRAM_ADDR_W'(bus.req_addr);
        end else if (wr_last) begin
            // Single-beat bursts never see a latched address, so take it directly.
            bus.dram_addr = (wcnt_q == '0) ? DRAM_ADDR_W'(bus.req_addr) : DRAM_ADDR_W'(addr_q);
        end
        bus.dram_read_rb  = pop;
        bus.resp_val      = pop;
        bus.resp_data     = bus.dram_rdata[DATA_W-1:0];
        bus.resp_tag      = tag_mem_q[rd_ptr_q];
        bus.resp_last     = (rcnt_q == LAST_BEAT);
        bus.err_unexp     = err_q;
    end

    always_comb begin
        init_cnt_d = ready_init ? init_cnt_q : init_cnt_q + INIT_W'(1);
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        rcnt_d     = rcnt_q;
        out_cnt_d  = out_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = err_q | (~bus.dram_rb_empty & (out_cnt_q == '0));
        if (wr_acc) begin
            wcnt_d = wr_last ? '0 : wcnt_q + BW'(1);
            if (wcnt_q == '0) addr_d = bus.req_addr;
        end
        if (pop) rcnt_d = pop_last ? '0 : rcnt_q + BW'(1);
        if (rd_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_last) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({rd_acc, pop_last})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            init_cnt_q <= '0;
            af_full_q  <= 1'b0;
            wb_full_q  <= 1'b0;
            rb_full_q  <= 1'b0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            addr_q     <= '0;
            out_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            init_cnt_q <= init_cnt_d;
            af_full_q  <= bus.dram_af_full;
            wb_full_q  <= bus.dram_wb_full;
            rb_full_q  <= bus.dram_rb_full;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            addr_q     <= addr_d;
            out_cnt_q  <= out_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    // Tag storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge gclk) begin
        if (rd_acc) tag_mem_q[wr_ptr_q] <= bus.req_tag;
    end

    generate
        if (DRAM_DATA_W > DATA_W) begin : g_rdata_hi
            logic unused_rdata_hi;
            assign unused_rdata_hi = ^bus.dram_rdata[DRAM_DATA_W-1:DATA_W];
        end
    endgenerate

`ifdef DRAMIF_STATS_EN
    logic [31:0] stat_rd_q, stat_rd_d, stat_wr_q, stat_wr_d;

    always_comb begin
        stat_rd_d = stat_rd_q;
        stat_wr_d = stat_wr_q;
        if (rd_acc && stat_rd_q != '1) stat_rd_d = stat_rd_q + 32'd1;
        if (wr_last && stat_wr_q != '1) stat_wr_d = stat_wr_q + 32'd1;
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            stat_rd_q <= stat_rd_d;
            stat_wr_q <= stat_wr_d;
        end
    end

    assign bus.stat_rd = stat_rd_q;
    assign bus.stat_wr = stat_wr_q;
`else
    assign bus.stat_rd = '0;
    assign bus.stat_wr = '0;
`endif
endmodule

// File: tb/tb_dram_user_adapter.sv
// Randomised scoreboard bench for dram_user_adapter: drivers push expected AF/WB/response
// entries, a monitor pops and compares them mid-cycle.
module tb_dram_user_adapter;
    localparam int ADDR_W      = 26;
    localparam int DATA_W      = 128;
    localparam int DRAM_ADDR_W = 28;
    localparam int DRAM_DATA_W = 144;
    localparam int BEATS       = 2;
    localparam int TAG_W       = 4;
    localparam int MAX_OUT     = 8;
    localparam int INIT_CYCLES = 8192;
    localparam int RESP_W      = DATA_W + TAG_W + 1;

    logic gclk = 1'b0;
    logic rst  = 1'b1;
    always #5 gclk = ~gclk;

    dram_user_adapter_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DRAM_ADDR_W(DRAM_ADDR_W),
        .DRAM_DATA_W(DRAM_DATA_W), .TAG_W(TAG_W)
    ) bus ();

    dram_user_adapter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DRAM_ADDR_W(DRAM_ADDR_W),
        .DRAM_DATA_W(DRAM_DATA_W), .BEATS(BEATS), .TAG_W(TAG_W),
        .MAX_OUT(MAX_OUT), .INIT_CYCLES(INIT_CYCLES)
    ) dut (
        .gclk(gclk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // Scoreboard: expected AF commands {read, addr}, WB data and response beats {data, tag, last}.
    logic [DRAM_ADDR_W:0]   exp_af[$];
    logic [DRAM_DATA_W-1:0] exp_wb[$];
    logic [RESP_W-1:0]      exp_resp[$];

    // Reference model: tags of accepted reads in issue order, beat position in the oldest read.
    logic [TAG_W-1:0] tq[$];
    int rbeat = 0;
    int n_rd  = 0;
    int n_wr  = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DRAM_DATA_W-1:0] rand_wide();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DRAM_DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DRAM_DATA_W-1:0] w;
        w = rand_wide();
        return w[DATA_W-1:0];
    endfunction

    // Monitor: sampled 3 time units after the falling edge, well clear of the rising edge.
    always begin
        @(negedge gclk);
        #3;
        if (mon_en) begin
            if (bus.dram_write_wb) begin
                if (exp_wb.size() == 0) check("wb_unexpected", 1, 0);
                else check("wb_data", bus.dram_wdata, exp_wb.pop_front());
            end
            if (bus.dram_write_af) begin
                if (exp_af.size() == 0) check("af_unexpected", 1, 0);
                else check("af_cmd", {bus.dram_read, bus.dram_addr}, exp_af.pop_front());
            end
            if (bus.resp_val) begin
                check("read_rb", bus.dram_read_rb, 1);
                if (exp_resp.size() == 0) check("resp_unexpected", 1, 0);
                else check("resp_beat", {bus.resp_data, bus.resp_tag, bus.resp_last}, exp_resp.pop_front());
            end
        end
    end

    // Drives one request beat from a falling edge and returns on the falling edge after acceptance.
    task automatic send_beat(input bit rw, input logic [ADDR_W-1:0] addr, input logic [TAG_W-1:0] tag,
                             input logic [DATA_W-1:0] data, input bit last);
        bit accepted;
        accepted     = 1'b0;
        bus.req_val  = 1'b1;
        bus.req_rw   = rw;
        bus.req_addr = addr;
        bus.req_tag  = tag;
        bus.req_data = data;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus.req_rdy) begin
                accepted = 1'b1;
                if (rw) begin
                    exp_wb.push_back(DRAM_DATA_W'(data));
                    if (last) begin
                        exp_af.push_back({1'b0, DRAM_ADDR_W'(addr)});
                        n_wr++;
                    end
                end else begin
                    exp_af.push_back({1'b1, DRAM_ADDR_W'(addr)});
                    tq.push_back(tag);
                    n_rd++;
                end
                @(negedge gclk);
                break;
            end
            @(negedge gclk);
        end
        check("req_accept", accepted, 1);
        bus.req_val = 1'b0;
    endtask

    task automatic write_burst(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d0,
                               input logic [DATA_W-1:0] d1);
        send_beat(1'b1, addr, TAG_W'($urandom()), d0, 1'b0);
        send_beat(1'b1, addr, TAG_W'($urandom()), d1, 1'b1);
    endtask

    // Presents one read-buffer beat for the current cycle and records the expected response.
    task automatic start_beat();
        logic [DRAM_DATA_W-1:0] d;
        bit last;
        d = rand_wide();
        last = (rbeat == BEATS - 1);
        bus.dram_rb_empty = 1'b0;
        bus.dram_rdata    = d;
        exp_resp.push_back({d[DATA_W-1:0], tq[0], last});
        if (last) void'(tq.pop_front());
        rbeat = last ? 0 : rbeat + 1;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && tq.size() > 0; i++) begin
            if ($urandom_range(0, 3) != 0) start_beat();
            else bus.dram_rb_empty = 1'b1;
            @(negedge gclk);
        end
        bus.dram_rb_empty = 1'b1;
        check("drain_done", tq.size(), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [ADDR_W-1:0] ra;
        bus.req_val = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_tag = '0; bus.req_data = '0;
        bus.dram_af_full = 1'b0; bus.dram_wb_full = 1'b0; bus.dram_rb_full = 1'b0;
        bus.dram_rb_empty = 1'b1; bus.dram_rdata = '0;

        // Reset: strobes and ready held low even with traffic offered.
        repeat (3) @(negedge gclk);
        bus.req_val = 1'b1; bus.req_rw = 1'b1; bus.dram_rb_empty = 1'b0;
        #1;
        check("rst_req_rdy", bus.req_rdy, 0);
        check("rst_write_wb", bus.dram_write_wb, 0);
        check("rst_write_af", bus.dram_write_af, 0);
        check("rst_read_rb", bus.dram_read_rb, 0);
        check("rst_resp_val", bus.resp_val, 0);
        @(negedge gclk);
        bus.req_val = 1'b0; bus.dram_rb_empty = 1'b1;
        @(negedge gclk);
        rst = 1'b0;
        #1;
        check("rst_err_unexp", bus.err_unexp, 0);
        check("rst_stat_rd", bus.stat_rd, 0);
        check("rst_stat_wr", bus.stat_wr, 0);

        // Init window: count cycles with req_rdy low while a read is offered.
        bus.req_val = 1'b1; bus.req_rw = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            if (i != 0) #1;
            if (bus.req_rdy) break;
            cnt++;
            @(negedge gclk);
        end
        bus.req_val = 1'b0;
        check("init_cycles", cnt, INIT_CYCLES);
        @(negedge gclk);
        mon_en = 1'b1;

        // Directed write burst at line 0x123.
        write_burst(ADDR_W'(26'h123), rand_data(), rand_data());

        // Fill all read credits, then hold a ninth read while the first response drains.
        for (int t = 0; t < MAX_OUT; t++) send_beat(1'b0, ADDR_W'($urandom()), TAG_W'(t), '0, 1'b0);
        ra = ADDR_W'($urandom());
        bus.req_val = 1'b1; bus.req_rw = 1'b0; bus.req_addr = ra; bus.req_tag = TAG_W'(8);
        #1 check("credit_full_rdy", bus.req_rdy, 0);
        @(negedge gclk);
        start_beat();
        #1 check("credit_pop1_rdy", bus.req_rdy, 0);
        @(negedge gclk);
        start_beat();
        #1 check("credit_pop2_rdy", bus.req_rdy, 0);
        @(negedge gclk);
        bus.dram_rb_empty = 1'b1;
        #1 check("credit_freed_rdy", bus.req_rdy, 1);
        exp_af.push_back({1'b1, DRAM_ADDR_W'(ra)});
        tq.push_back(TAG_W'(8));
        n_rd++;
        @(negedge gclk);
        bus.req_val = 1'b0;
        drain();

        // Read offered mid write burst must wait for the second beat.
        ra = ADDR_W'($urandom());
        send_beat(1'b1, ADDR_W'(26'h2a5), '0, rand_data(), 1'b0);
        bus.req_val = 1'b1; bus.req_rw = 1'b0; bus.req_addr = ra; bus.req_tag = TAG_W'(5);
        #1 check("mid_burst_rdy0", bus.req_rdy, 0);
        @(negedge gclk);
        #1 check("mid_burst_rdy1", bus.req_rdy, 0);
        @(negedge gclk);
        send_beat(1'b1, ADDR_W'(26'h2a5), '0, rand_data(), 1'b1);
        send_beat(1'b0, ra, TAG_W'(5), '0, 1'b0);
        drain();

        // One-cycle full pulses throttle req_rdy one cycle later, for exactly one cycle.
        bus.req_rw = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.dram_af_full = (k == 0); bus.dram_wb_full = (k == 1); bus.dram_rb_full = (k == 2);
            #1 check("bp_same_cycle", bus.req_rdy, 1);
            @(negedge gclk);
            bus.dram_af_full = 1'b0; bus.dram_wb_full = 1'b0; bus.dram_rb_full = 1'b0;
            #1 check("bp_delayed", bus.req_rdy, 0);
            @(negedge gclk);
            #1 check("bp_release", bus.req_rdy, 1);
            @(negedge gclk);
        end

        // Random mix of write bursts, reads and read-buffer beats.
        for (int n = 0; n < 80; n++) begin
            int op;
            op = $urandom_range(0, 2);
            if (tq.size() == MAX_OUT || (op == 0 && tq.size() > 0)) begin
                start_beat();
                @(negedge gclk);
                bus.dram_rb_empty = 1'b1;
            end else if (op == 1) begin
                write_burst(ADDR_W'($urandom()), rand_data(), rand_data());
            end else begin
                send_beat(1'b0, ADDR_W'($urandom()), TAG_W'($urandom()), '0, 1'b0);
            end
        end
        drain();
        repeat (2) @(negedge gclk);

`ifdef DRAMIF_STATS_EN
        check("stat_rd", bus.stat_rd, n_rd);
        check("stat_wr", bus.stat_wr, n_wr);
`else
        check("stat_rd_off", bus.stat_rd, 0);
        check("stat_wr_off", bus.stat_wr, 0);
`endif

        // Data with nothing outstanding: flagged, not popped, and sticky.
        check("err_before", bus.err_unexp, 0);
        bus.dram_rb_empty = 1'b0; bus.dram_rdata = rand_wide();
        #1 check("unexp_no_pop", bus.dram_read_rb, 0);
        @(negedge gclk);
        bus.dram_rb_empty = 1'b1;
        #1 check("err_set", bus.err_unexp, 1);
        repeat (3) @(negedge gclk);
        #1 check("err_sticky", bus.err_unexp, 1);

        repeat (2) @(negedge gclk);
        check("af_queue_empty", exp_af.size(), 0);
        check("wb_queue_empty", exp_wb.size(), 0);
        check("resp_queue_empty", exp_resp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_user_adapter.md
Name: dram_user_adapter

Overview:
Parametrised bridge between the core-side memory request/response channel and the DRAM controller's FIFO-style user interface (address FIFO, write buffer, read buffer).
- Supports configurable data and address widths and a configurable number of data beats per request.
- Returns read data with a tag and a last-beat flag.
- Limits outstanding reads with a credit counter so the controller read buffer cannot overflow.
- Sits between the memory-side cache/arbiter and the DRAM controller, in the same clock domain as both.

Parameters:
ADDR_W, 26, request address width (line address)
DATA_W, 128, request/response data width per beat
DRAM_ADDR_W, 28, controller address width; request address zero-extended
DRAM_DATA_W, 144, controller data width; DATA_W zero-extended on write, low DATA_W bits taken on read
BEATS, 2, data beats per request (power of two, 1..8)
TAG_W, 4, request tag width
MAX_OUT, 8, maximum outstanding read requests (power of two, 2..32)
INIT_CYCLES, 8192, post-reset cycles before the adapter accepts any request

Ports:
gclk  in  1  clock
rst  in  1  synchronous active-high reset
req_val  in  1  request beat valid
req_rdy  out  1  request beat accepted when req_val & req_rdy
req_rw  in  1  1 = write beat, 0 = read
req_addr  in  ADDR_W  line address
req_tag  in  TAG_W  read tag (ignored on writes)
req_data  in  DATA_W  write beat data
resp_val  out  1  response beat valid (no backpressure)
resp_data  out  DATA_W  response beat data
resp_tag  out  TAG_W  tag of the read being returned
resp_last  out  1  final beat of a read response
err_unexp  out  1  sticky: read data arrived with no read outstanding
dram_addr  out  DRAM_ADDR_W  controller address
dram_read  out  1  1 = read command
dram_write_af  out  1  address FIFO write enable
dram_af_full  in  1  address FIFO full
dram_wdata  out  DRAM_DATA_W  write buffer data
dram_write_wb  out  1  write buffer write enable
dram_wb_full  in  1  write buffer full
dram_rdata  in  DRAM_DATA_W  read buffer data
dram_read_rb  out  1  read buffer pop
dram_rb_empty  in  1  read buffer empty
dram_rb_full  in  1  read buffer full
stat_rd  out  32  read commands issued (see optional feature)
stat_wr  out  32  write commands issued (see optional feature)

Behaviour:
Reset:
- Reset state: all counters 0, tag FIFO empty, err_unexp = 0, req_rdy = 0, resp_val = 0.
- Strobe outputs (write_af, write_wb, read_rb) are 0 while rst is high.

Init:
- init_cnt counts to INIT_CYCLES and then saturates; ready_init = (init_cnt == INIT_CYCLES).

Back-pressure:
- af_full, wb_full and rb_full are registered one cycle (1-cycle pessimism accepted).
- base_rdy = ready_init & ~af_full_q & ~wb_full_q & ~rb_full_q.

Write bursts:
- A write is exactly BEATS consecutive accepted beats with req_rw = 1.
- Each accepted beat drives dram_write_wb = 1 and dram_wdata = zero-extended req_data in the same cycle.
- Beat counter wcnt is log2(BEATS) bits, increments per accepted write beat and wraps to 0.
- Address is latched on the beat where wcnt == 0.
- dram_write_af asserts on the beat where wcnt == BEATS-1, with dram_read = 0 and dram_addr = latched address.
- With BEATS = 1, AF and WB are written on the same cycle, using the current address.

Reads:
- A read is a single beat with req_rw = 0.
- The read is accepted only when wcnt == 0 and out_cnt < MAX_OUT.
- On acceptance: dram_write_af = 1, dram_read = 1, dram_addr = req_addr; req_tag is pushed into the tag FIFO (depth MAX_OUT) and out_cnt increments.

req_rdy:
- req_rdy = base_rdy & (req_rw ? 1 : (wcnt == 0 & out_cnt < MAX_OUT)).
- A read presented mid write burst stalls until that burst completes.

Response path:
- dram_read_rb = resp_val = ~dram_rb_empty & (out_cnt != 0).
- resp_data = dram_rdata[DATA_W-1:0]; resp_tag = tag FIFO head.
- rcnt counts popped beats; resp_last = (rcnt == BEATS-1).
- On a last-beat pop: the tag FIFO pops, out_cnt decrements and rcnt wraps to 0.

Simultaneous accept and final pop:
- out_cnt is unchanged; the tag FIFO pushes and pops in the same cycle.
- A read may be accepted in the same cycle out_cnt drops from MAX_OUT only if the registered count already allows it. There is no bypass; the credit frees on the following cycle.

Unexpected data:
- If ~dram_rb_empty while out_cnt == 0, err_unexp is set and remains set until rst.
- The data is not popped.

Reset mid-operation:
- Any partial write burst and all outstanding tags are discarded.
- The DRAM controller must be reset in the same cycle; the adapter does not drain.

Optional Feature:
DRAMIF_STATS_EN
- Defined: stat_rd and stat_wr are 32-bit counters, incremented on each read command and each write command respectively. A write command is an AF write, not a beat. Both counters saturate at 0xFFFFFFFF and clear on rst.
- Undefined: stat_rd and stat_wr are tied to 0 and no counter logic is generated.

Test Plan:
- rst released, req_val held high -> req_rdy stays 0 for exactly INIT_CYCLES = 8192 cycles, then goes 1.
- BEATS = 2: write addr 0x123, data A then B -> two write_wb pulses with A and B; one write_af on the second beat with dram_addr = 0x0000123, dram_read = 0.
- Issue 8 reads with tags 0..7 while rb_empty = 1 -> req_rdy drops after the 8th read; a 9th read stalls. Pop 2 beats -> resp_last on beat 2 with tag 0; the 9th read is accepted the next cycle.
- Read presented after the first write beat (wcnt = 1) -> not accepted until the second write beat completes; the AF order is write then read.
- dram_af_full pulsed high for 1 cycle -> req_rdy low for exactly 1 cycle, delayed by 1 cycle. rb_empty = 0 with no outstanding reads -> err_unexp = 1 and remains 1.
- DRAMIF_STATS_EN defined: 3 writes and 5 reads -> stat_wr = 3, stat_rd = 5. Without the macro, both read 0.
